stack_ctrl: RTL and testbench

Parametrised hardware stack controller driving a single-port, synchronous-read RAM: read address in cycle N, data in cycle N+1. It is the successor of the 16-bit push/pop stack. It adds configurable data and address widths, bounded stack space, full/empty flags with an occupancy count, and a valid/ready command handshake. It also adds PEEK and REPLACE operations, a response channel with error reporting, and sticky overflow/underflow flags. It sits between the CPU control unit (CALL/RET/PUSH/POP microcode) and the data RAM port arbiter.

---
 rtl/stack_ctrl.sv | 169 ++++++++++++++++
 tb/tb_stack_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Full-descending hardware stack controller in front of a single-port RAM
// with synchronous read (address in cycle N, data in cycle N+1).
// The stack holds elements at addresses sp .. SP_EMPTY-1. Its capacity is
// SP_EMPTY - SP_LIMIT words.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_op 0 PUSH, 1 POP, 2 PEEK, 3 REPLACE
//   cmd_wdata           data for PUSH / REPLACE
//   mem_we/addr/wdata   RAM write enable, address and write data
//   mem_rdata           RAM read data, valid one cycle after its address
//   rsp_valid/data/err  one-cycle POP/PEEK result; err marks an empty stack
//   sp, count           stack pointer (top element) and occupancy
//   empty, full         sp == SP_EMPTY, sp == SP_LIMIT
//   err_clr             clears the sticky error flags (a coincident set wins)
//   err_overflow        sticky: PUSH attempted while full
//   err_underflow       sticky: POP/PEEK/REPLACE attempted while empty
//
// state   | meaning
// IDLE    | ready for a command; PUSH/REPLACE finish here in one cycle
// RD_WAIT | RAM read in flight; response is registered at the end of this cycle
// -----------------------------------------------------------------------------
module stack_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] SP_EMPTY = 16'hFFFE,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 16'h8000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] count,
    output logic              empty,
    output logic              full,
    input  logic              err_clr,
    output logic              err_overflow,
    output logic              err_underflow
);

    if (SP_LIMIT >= SP_EMPTY) begin : g_cfg_check
        $fatal(1, "stack_ctrl: SP_LIMIT must be strictly below SP_EMPTY");
    end

    localparam logic [1:0] OP_PUSH    = 2'd0;
    localparam logic [1:0] OP_POP     = 2'd1;
    localparam logic [1:0] OP_PEEK    = 2'd2;
    localparam logic [1:0] OP_REPLACE = 2'd3;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_err;

    logic              accept;
    logic [ADDR_W-1:0] sp_dec;
    logic [ADDR_W-1:0] sp_inc;
    logic              ovf_set;
    logic              udf_set;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign sp    = sp_q;
    assign count = SP_EMPTY - sp_q;
    assign empty = (sp_q == SP_EMPTY);
    assign full  = (sp_q == SP_LIMIT);

    assign sp_dec = sp_q - ADDR_W'(1);
    assign sp_inc = sp_q + ADDR_W'(1);

    // An error event is either a PUSH into a full stack or any other op on an empty one.
    assign ovf_set = accept && (cmd_op == OP_PUSH) && full;
    assign udf_set = accept && (cmd_op != OP_PUSH) && empty;

    assign mem_wdata = cmd_wdata;

    // The RAM port is combinational so a PUSH writes on the edge that accepts it.
    // A POP/PEEK presents the read address through the default path (sp).
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = (state == RD_WAIT) ? rd_addr : sp_q;
        if (accept) begin
            case (cmd_op)
                OP_PUSH: begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        mem_addr = sp_dec;
                    end
                end
                OP_REPLACE: begin
                    if (!empty) begin
                        mem_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sp_q          <= SP_EMPTY;
            rd_addr       <= SP_EMPTY;
            rd_err        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            rsp_valid     <= 1'b0;
            // A set in the same cycle as err_clr takes priority.
            err_overflow  <= ovf_set || (err_overflow && !err_clr);
            err_underflow <= udf_set || (err_underflow && !err_clr);

            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (!full) sp_q <= sp_dec;
                            end
                            OP_POP: begin
                                rd_addr <= sp_q;
                                rd_err  <= empty;
                                if (!empty) sp_q <= sp_inc;
                                state   <= RD_WAIT;
                            end
                            OP_PEEK: begin
                                rd_addr <= sp_q;
                                rd_err  <= empty;
                                state   <= RD_WAIT;
                            end
                            default: ;
                        endcase
                    end
                end
                RD_WAIT: begin
                    // An empty-stack read still takes this cycle so both outcomes share one latency.
                    rsp_valid <= 1'b1;
                    rsp_err   <= rd_err;
                    rsp_data  <= rd_err ? '0 : mem_rdata;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
// Two stack_ctrl instances are driven by one command stream: a default
// configuration and a small 4-word configuration (SP_EMPTY=0x10, SP_LIMIT=0x0C).
// The reference model is an array-backed stack with a depth counter.
// The driver pushes the expected POP/PEEK responses into a queue. A monitor
// pops that queue and compares whenever rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;

    localparam logic [15:0] E0 = 16'hFFFE;
    localparam logic [15:0] L0 = 16'h8000;
    localparam logic [15:0] E1 = 16'h0010;
    localparam logic [15:0] L1 = 16'h000C;

    localparam logic [1:0] PUSH = 2'd0, POP = 2'd1, PEEK = 2'd2, REPL = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic        err_clr = 1'b0;

    logic [1:0]  cmd_ready, mem_we, rsp_valid, rsp_err, empty, full, err_overflow, err_underflow;
    logic [15:0] mem_addr [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic [15:0] rsp_data [2];
    logic [15:0] sp [2];
    logic [15:0] count [2];

    logic [15:0] ram0 [0:65535];
    logic [15:0] ram1 [0:65535];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stack_ctrl u_big (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .cmd_ready(cmd_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .sp(sp[0]), .count(count[0]), .empty(empty[0]), .full(full[0]), .err_clr(err_clr),
        .err_overflow(err_overflow[0]), .err_underflow(err_underflow[0])
    );

    stack_ctrl #(.SP_EMPTY(16'h0010), .SP_LIMIT(16'h000C)) u_small (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .cmd_ready(cmd_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .sp(sp[1]), .count(count[1]), .empty(empty[1]), .full(full[1]), .err_clr(err_clr),
        .err_overflow(err_overflow[1]), .err_underflow(err_underflow[1])
    );

    // Synchronous-read RAMs
    always @(posedge clk) begin
        if (mem_we[0]) ram0[mem_addr[0]] <= mem_wdata[0];
        mem_rdata[0] <= ram0[mem_addr[0]];
        if (mem_we[1]) ram1[mem_addr[1]] <= mem_wdata[1];
        mem_rdata[1] <= ram1[mem_addr[1]];
    end

    // Reference model: stk[k][0..depth-1], top at depth-1
    logic [15:0] stk [2][0:255];
    int          depth [2];
    logic        m_ovf [2];
    logic        m_udf [2];

    typedef struct {
        int          k;
        logic        err;
        logic [15:0] data;
        int          cyc;
    } rsp_t;
    rsp_t exp_q[$];

    function automatic logic [15:0] e_of(int k);
        return (k == 0) ? E0 : E1;
    endfunction

    function automatic int cap_of(int k);
        return (k == 0) ? int'(E0 - L0) : int'(E1 - L1);
    endfunction

    function automatic logic [15:0] m_sp(int k);
        return e_of(k) - 16'(depth[k]);
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s inst=%0d actual=%0h expected=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k]) begin
                    int idx;
                    idx = -1;
                    foreach (exp_q[i]) if (idx < 0 && exp_q[i].k == k) idx = i;
                    if (idx < 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL rsp_unexpected inst=%0d actual rsp_valid=1 expected no response", k);
                    end else begin
                        chk("rsp_data", k, rsp_data[k], exp_q[idx].data);
                        chk("rsp_err", k, rsp_err[k], exp_q[idx].err);
                        chk("rsp_cycle", k, cyc, exp_q[idx].cyc);
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    // Called at a negedge. Waits for cmd_ready, then presents one cycle of
    // inputs. Returns at the negedge of the following cycle.
    task automatic step(bit v, logic [1:0] op, logic [15:0] wd, bit clr);
        int   guard;
        bit   rd;
        logic exp_we [2];
        logic [15:0] exp_addr [2];
        logic [15:0] rd_addr [2];
        cmd_valid = v;
        cmd_op    = op;
        cmd_wdata = wd;
        err_clr   = 1'b0;
        guard = 0;
        while (!cmd_ready[0] && guard < 10) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout inst=0 actual cmd_ready=0 expected 1 within 10 cycles");
        end
        err_clr = clr;
        #1;
        rd = v && (op == POP || op == PEEK);
        for (int k = 0; k < 2; k++) begin
            bit so, su;
            so = 0;
            su = 0;
            exp_we[k]   = 1'b0;
            exp_addr[k] = m_sp(k);
            rd_addr[k]  = m_sp(k);
            if (v) begin
                case (op)
                    PUSH: begin
                        if (depth[k] == cap_of(k)) so = 1;
                        else begin
                            exp_we[k] = 1'b1;
                            exp_addr[k] = m_sp(k) - 16'd1;
                            stk[k][depth[k]] = wd;
                            depth[k]++;
                        end
                    end
                    POP, PEEK: begin
                        rsp_t r;
                        r.k = k;
                        r.cyc = cyc + 2;
                        if (depth[k] == 0) begin
                            su = 1;
                            r.err = 1'b1;
                            r.data = 16'h0;
                        end else begin
                            r.err = 1'b0;
                            r.data = stk[k][depth[k]-1];
                            if (op == POP) depth[k]--;
                        end
                        exp_q.push_back(r);
                    end
                    default: begin
                        if (depth[k] == 0) su = 1;
                        else begin
                            exp_we[k] = 1'b1;
                            stk[k][depth[k]-1] = wd;
                        end
                    end
                endcase
            end
            m_ovf[k] = so ? 1'b1 : (clr ? 1'b0 : m_ovf[k]);
            m_udf[k] = su ? 1'b1 : (clr ? 1'b0 : m_udf[k]);
            chk("mem_we", k, mem_we[k], exp_we[k]);
            chk("mem_addr", k, mem_addr[k], exp_addr[k]);
            chk("mem_wdata", k, mem_wdata[k], wd);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("sp", k, sp[k], m_sp(k));
            chk("count", k, count[k], depth[k]);
            chk("empty", k, empty[k], depth[k] == 0);
            chk("full", k, full[k], depth[k] == cap_of(k));
            chk("err_overflow", k, err_overflow[k], m_ovf[k]);
            chk("err_underflow", k, err_underflow[k], m_udf[k]);
            chk("cmd_ready", k, cmd_ready[k], !rd);
            if (rd) begin
                chk("rd_wait_addr", k, mem_addr[k], rd_addr[k]);
                chk("rd_wait_we", k, mem_we[k], 1'b0);
            end
        end
    endtask

    // Called at a negedge: asserts reset, checks reset values, releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        err_clr = 1'b0;
        #1;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            depth[k] = 0;
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
            chk("rst_sp", k, sp[k], e_of(k));
            chk("rst_count", k, count[k], 0);
            chk("rst_empty", k, empty[k], 1);
            chk("rst_full", k, full[k], 0);
            chk("rst_ready", k, cmd_ready[k], 1);
            chk("rst_rsp_valid", k, rsp_valid[k], 0);
            chk("rst_rsp_data", k, rsp_data[k], 0);
            chk("rst_rsp_err", k, rsp_err[k], 0);
            chk("rst_ovf", k, err_overflow[k], 0);
            chk("rst_udf", k, err_underflow[k], 0);
            chk("rst_mem_we", k, mem_we[k], 0);
            chk("rst_mem_addr", k, mem_addr[k], e_of(k));
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=time limit reached expected=bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Back-to-back pushes, then pops
        step(1, PUSH, 16'h1111, 0);
        step(1, PUSH, 16'h2222, 0);
        step(1, PUSH, 16'h3333, 0);
        step(1, POP, 16'h0, 0);
        step(1, POP, 16'h0, 0);
        step(1, POP, 16'h0, 0);
        step(0, PUSH, 16'h0, 0);

        // PEEK / REPLACE
        step(1, PUSH, 16'hABCD, 0);
        step(1, PEEK, 16'h0, 0);
        step(1, REPL, 16'h5555, 0);
        step(1, POP, 16'h0, 0);
        step(0, PUSH, 16'h0, 0);

        // Underflow, clear, and set-beats-clear
        step(1, POP, 16'h0, 0);
        step(0, PUSH, 16'h0, 0);
        step(0, PUSH, 16'h0, 1);
        step(1, PEEK, 16'h0, 1);
        step(1, REPL, 16'h7777, 0);
        step(0, PUSH, 16'h0, 1);

        // Small instance fills at four words; fifth push overflows
        for (int i = 0; i < 5; i++) step(1, PUSH, 16'(16'hA0 + i), 0);
        step(1, PUSH, 16'hBEEF, 1);
        for (int i = 0; i < 6; i++) step(1, POP, 16'h0, 0);
        step(0, PUSH, 16'h0, 1);

        // Reset while a POP is in RD_WAIT, then normal operation
        step(1, PUSH, 16'h4242, 0);
        step(1, POP, 16'h0, 0);
        do_reset();
        repeat (3) @(negedge clk);
        step(1, PUSH, 16'h9999, 0);
        step(1, POP, 16'h0, 0);
        step(0, PUSH, 16'h0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit          v;
            logic [1:0]  op;
            logic [15:0] wd;
            bit          clr;
            v   = ($urandom_range(0, 3) != 0);
            op  = 2'($urandom_range(0, 3));
            wd  = 16'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            if (depth[0] >= 200 && op == PUSH) op = POP;
            step(v, op, wd, clr);
        end

        repeat (4) @(negedge clk);
        chk("rsp_drain", 0, exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
